// File: rtl/nn_reset_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package nn_reset_pkg;

   typedef enum logic [2:0] {
      SYNC  = 3'd0,
      DELAY = 3'd1,
      ACK   = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam int DEF_NUM_STAGES  = 4;
   localparam int DEF_STAGE_DELAY = 16;
   localparam int DEF_ACK_TIMEOUT = 1024;
   localparam int DEF_SYNC_STAGES = 2;

   // One counter serves both the delay and the ack wait, so size it for the larger.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/nn_reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES edges.
module nn_reset_sync
   import nn_reset_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input  logic clk,
   input  logic reset,
   output logic rst_sync
);

   logic [SYNC_STAGES-1:0] chain;

   // Shift ones in once the raw reset is released; clear at once when it falls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/nn_reset_sequencer.sv
// Releases NUM_STAGES downstream active-low resets in order, each after a
// fixed delay and gated on the previous stage's init_done acknowledgment.
module nn_reset_sequencer
   import nn_reset_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int STAGE_DELAY = DEF_STAGE_DELAY,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          soft_reset,
   input  logic [NUM_STAGES-1:0]         init_done,
   output logic [NUM_STAGES-1:0]         stage_reset,
   output logic [$clog2(NUM_STAGES):0]   cur_stage,
   output logic                          all_ready,
   output logic                          timeout_err
);

   localparam int IW = $clog2(NUM_STAGES) + 1;
   localparam int CW = cnt_width(STAGE_DELAY, ACK_TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);
   localparam logic [IW-1:0] DONE_IDX  = IW'(NUM_STAGES);
   localparam logic [CW-1:0] DELAY_END = CW'(STAGE_DELAY - 1);
   localparam logic [CW-1:0] ACK_END   = CW'(ACK_TIMEOUT - 1);

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    rst_sync;
   logic [NUM_STAGES-1:0]   sel;
   logic                    ack;

   nn_reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .rst_sync (rst_sync)
   );

   // cur_stage doubles as the stage index; decode it to a one-hot select so
   // only the current stage's init_done is looked at.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         if (cur_stage == IW'(i)) sel[i] = 1'b1;
      ack = |(sel & init_done);
   end

   // Sequencing FSM; soft_reset overrides everything except the initial sync wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= SYNC;
         cnt         <= '0;
         cur_stage   <= '0;
         stage_reset <= '0;
         all_ready   <= 1'b0;
         timeout_err <= 1'b0;
      end else if (soft_reset && state != SYNC) begin
         state       <= DELAY;
         cnt         <= '0;
         cur_stage   <= '0;
         stage_reset <= '0;
         all_ready   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            SYNC: begin
               if (rst_sync) begin
                  state     <= DELAY;
                  cnt       <= '0;
                  cur_stage <= '0;
               end
            end
            DELAY: begin
               if (cnt == DELAY_END) begin
                  stage_reset <= stage_reset | sel;
                  cnt         <= '0;
                  state       <= ACK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ACK: begin
               if (ack) begin
                  cnt <= '0;
                  if (cur_stage == LAST_IDX) begin
                     state     <= DONE;
                     all_ready <= 1'b1;
                     cur_stage <= DONE_IDX;
                  end else begin
                     state     <= DELAY;
                     cur_stage <= cur_stage + 1'b1;
                  end
               end else if (cnt == ACK_END) begin
                  state       <= ERROR;
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE, ERROR: ;
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_reset_sequencer.sv
// Directed bench for nn_reset_sequencer at default parameters.
module tb_nn_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       soft_reset;
   logic [3:0] init_done;
   logic [3:0] stage_reset;
   logic [2:0] cur_stage;
   logic       all_ready;
   logic       timeout_err;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   nn_reset_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .soft_reset  (soft_reset),
      .init_done   (init_done),
      .stage_reset (stage_reset),
      .cur_stage   (cur_stage),
      .all_ready   (all_ready),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then sample 1ns later.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic goto_edge(input int e);
      step(e - edge_n);
   endtask

   // Pulse reset across one edge, release between edges, restart edge count.
   task automatic restart();
      reset = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      edge_n = 0;
   endtask

   initial begin
      reset      = 1'b0;
      soft_reset = 1'b0;
      init_done  = 4'b1111;
      #2;
      chk("rst_stage_reset", 32'(stage_reset), 32'h0);
      chk("rst_all_ready",   32'(all_ready),   32'h0);
      chk("rst_timeout",     32'(timeout_err), 32'h0);
      chk("rst_cur_stage",   32'(cur_stage),   32'h0);

      // Power-up with immediate acks
      @(posedge clk);
      #3 reset = 1'b1;
      edge_n = 0;
      goto_edge(18); chk("pu_e18_sr",  32'(stage_reset), 32'h0);
      goto_edge(19); chk("pu_e19_sr",  32'(stage_reset), 32'h1);
                     chk("pu_e19_cur", 32'(cur_stage),   32'd0);
      goto_edge(35); chk("pu_e35_sr",  32'(stage_reset), 32'h1);
      goto_edge(36); chk("pu_e36_sr",  32'(stage_reset), 32'h3);
                     chk("pu_e36_cur", 32'(cur_stage),   32'd1);
      goto_edge(53); chk("pu_e53_sr",  32'(stage_reset), 32'h7);
      goto_edge(70); chk("pu_e70_sr",  32'(stage_reset), 32'hf);
                     chk("pu_e70_rdy", 32'(all_ready),   32'h0);
      goto_edge(71); chk("pu_e71_rdy", 32'(all_ready),   32'h1);
                     chk("pu_e71_cur", 32'(cur_stage),   32'd4);
      init_done = 4'b0000;
      step(5);
      chk("done_hold_rdy", 32'(all_ready),   32'h1);
      chk("done_hold_sr",  32'(stage_reset), 32'hf);

      // Stage 2 acks 40 cycles late
      init_done = 4'b1011;
      restart();
      goto_edge(53);  chk("late_e53_sr",  32'(stage_reset), 32'h7);
      goto_edge(93);  chk("late_e93_sr",  32'(stage_reset), 32'h7);
                      chk("late_e93_cur", 32'(cur_stage),   32'd2);
      init_done = 4'b1111;
      goto_edge(109); chk("late_e109_sr",  32'(stage_reset), 32'h7);
      goto_edge(110); chk("late_e110_sr",  32'(stage_reset), 32'hf);
                      chk("late_e110_rdy", 32'(all_ready),   32'h0);
      goto_edge(111); chk("late_e111_rdy", 32'(all_ready),   32'h1);

      // Stage 1 never acks -> timeout
      init_done = 4'b1101;
      restart();
      goto_edge(36);   chk("to_e36_sr",    32'(stage_reset), 32'h3);
      goto_edge(1059); chk("to_e1059_err", 32'(timeout_err), 32'h0);
      goto_edge(1060); chk("to_e1060_err", 32'(timeout_err), 32'h1);
                       chk("to_e1060_sr",  32'(stage_reset), 32'h3);
                       chk("to_e1060_cur", 32'(cur_stage),   32'd1);
                       chk("to_e1060_rdy", 32'(all_ready),   32'h0);
      step(100);
      chk("to_hold_err", 32'(timeout_err), 32'h1);
      chk("to_hold_sr",  32'(stage_reset), 32'h3);
      chk("to_hold_cur", 32'(cur_stage),   32'd1);

      // soft_reset out of ERROR
      soft_reset = 1'b1;
      init_done  = 4'b1111;
      step(1);
      soft_reset = 1'b0;
      chk("sr_err_sr",  32'(stage_reset), 32'h0);
      chk("sr_err_err", 32'(timeout_err), 32'h0);
      chk("sr_err_cur", 32'(cur_stage),   32'd0);
      step(15); chk("sr_err_d15_sr", 32'(stage_reset), 32'h0);
      step(1);  chk("sr_err_d16_sr", 32'(stage_reset), 32'h1);

      // Async reset mid-ACK of stage 2
      init_done = 4'b1011;
      restart();
      goto_edge(60);
      chk("ar_pre_sr", 32'(stage_reset), 32'h7);
      #2 reset = 1'b0;
      #1;
      chk("ar_now_sr",  32'(stage_reset), 32'h0);
      chk("ar_now_rdy", 32'(all_ready),   32'h0);
      chk("ar_now_cur", 32'(cur_stage),   32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      edge_n = 0;
      init_done = 4'b1111;
      goto_edge(18); chk("ar_e18_sr", 32'(stage_reset), 32'h0);
      goto_edge(19); chk("ar_e19_sr", 32'(stage_reset), 32'h1);

      // soft_reset ignored during SYNC, then coincident with stage 3 ack
      init_done = 4'b0111;
      restart();
      soft_reset = 1'b1;
      step(2);
      soft_reset = 1'b0;
      goto_edge(18); chk("sync_soft_e18_sr", 32'(stage_reset), 32'h0);
      goto_edge(19); chk("sync_soft_e19_sr", 32'(stage_reset), 32'h1);
      goto_edge(70); chk("co_e70_sr", 32'(stage_reset), 32'hf);
      init_done  = 4'b1111;
      soft_reset = 1'b1;
      step(1);
      soft_reset = 1'b0;
      chk("co_e71_rdy", 32'(all_ready),   32'h0);
      chk("co_e71_sr",  32'(stage_reset), 32'h0);
      chk("co_e71_cur", 32'(cur_stage),   32'd0);
      step(1);  chk("co_e72_rdy", 32'(all_ready),   32'h0);
      goto_edge(86); chk("co_e86_sr", 32'(stage_reset), 32'h0);
      goto_edge(87); chk("co_e87_sr", 32'(stage_reset), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
